branch_predictor_unit: RTL
==========================

# branch_predictor_unit

Front-end branch predictor for the STRV32I core. It predicts taken/not-taken and the next-PC target for every fetched instruction from a bimodal table of 2-bit saturating counters. It consumes the branch unit's resolved `branch_taken` decision in execute to train the table and detect mispredictions. On a misprediction it issues a registered one-cycle redirect/flush to the PC stage.

## Interface
Parameters:
- `INDEX_W`, default 4: BHT index width; table holds 2^INDEX_W entries of 2 bits.

Ports:
- `clk_in`  input  1  core clock; all state updates on the rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `fetch_valid_in`  input  1  fetch-stage instruction valid.
- `fetch_pc_in`  input  32  PC of the fetched instruction.
- `fetch_opcode_6_to_2_in`  input  5  opcode[6:2] of the fetched instruction.
- `fetch_imm_in`  input  32  sign-extended B/J immediate (pre-decoded).
- `predict_taken_out`  output  1  combinational prediction for the fetch instruction.
- `predict_target_out`  output  32  combinational predicted next PC.
- `ex_valid_in`  input  1  execute-stage instruction valid.
- `ex_pc_in`  input  32  PC of the execute instruction.
- `ex_opcode_6_to_2_in`  input  5  opcode[6:2] in execute.
- `ex_predicted_taken_in`  input  1  prediction carried down the pipe with this instruction.
- `branch_taken_in`  input  1  resolved decision from the branch unit.
- `ex_target_in`  input  32  resolved target address (pc+imm or rs1+imm, LSB cleared).
- `mispredict_out`  output  1  registered one-cycle redirect/flush pulse.
- `redirect_pc_out`  output  32  registered correct next PC; valid while `mispredict_out` is 1.
- `branch_count_out`  output  16  resolved control-transfer count; wraps.
- `mispredict_count_out`  output  16  misprediction count; wraps.

## Operation
- Index: `idx = pc[INDEX_W+1:2]`, taken from `fetch_pc_in` for prediction and from `ex_pc_in` for update.
- Prediction is combinational and depends on `fetch_opcode_6_to_2_in`:
  - 11011 (JAL): taken, target = `fetch_pc_in + fetch_imm_in`.
  - 11001 (JALR): not taken, target = `fetch_pc_in + 4`. The target is unknown at fetch, so every JALR mispredicts.
  - 11000 (branch): taken iff `bht[idx][1]` is 1. Target is pc+imm if taken, pc+4 otherwise.
  - All other opcodes: not taken, target = pc+4.
  - When `fetch_valid_in` is 0: both outputs are still driven per the above; the consumer ignores them.
- Resolution qualifier: `res = ex_valid_in & ~mispredict_out`. The instruction in execute during a flush cycle is squashed and ignored.
- Training: on `res` with opcode 11000, `bht[idx]` increments (saturating at 11) if `branch_taken_in` is 1, and decrements (saturating at 00) otherwise. JAL, JALR and other opcodes never train.
- Mispredict: `res & (op is 11000, 11011 or 11001) & (branch_taken_in != ex_predicted_taken_in)`.
- Redirect PC: `ex_target_in` if `branch_taken_in` is 1, otherwise `ex_pc_in + 4`.
- Counters: `branch_count_out` increments on `res` with op in {11000, 11011, 11001}. `mispredict_count_out` increments on mispredict. Both are modulo 2^16.
- All arithmetic is 32-bit modulo 2^32; pc+4 at 0xFFFFFFFC wraps to 0.

## Timing
- Reset (asynchronous assert): every BHT entry = 01 (weakly not taken); `mispredict_out` = 0; `redirect_pc_out` = 0; both counters = 0. Deassertion is sampled on `clk_in`.
- Reset mid-operation: a pending redirect is dropped and the table clears immediately.
- Prediction has zero latency: it reflects BHT state at the start of the cycle.
- Same-cycle read/update on the same index: fetch sees the old counter value (read-before-write). The update is visible from the next cycle.
- `mispredict_out` and `redirect_pc_out` register at the edge following resolution (latency 1).
  - `mispredict_out` is high for exactly one cycle.
  - `redirect_pc_out` holds its last value when `mispredict_out` is 0.
- Back-to-back resolutions: each cycle is evaluated independently, except the cycle in which `mispredict_out` = 1. No two consecutive mispredict pulses can arise from adjacent execute instructions.
- BHT and counter updates occur on the same edge as the `mispredict_out` register.

## Test plan
- Reset: hold `rst_n_in` = 0 → `mispredict_out` = 0, both counts = 0. A BEQ at PC 0x100 with imm 0x20 predicts not taken, target 0x104.
- Training: resolve three taken BEQ at PC 0x100.
  - Mispredict pulse on the first only; `redirect_pc_out` = `ex_target_in` = 0x120.
  - Counter goes 01→10→11→11; fetch at 0x100 then predicts taken, target 0x120.
  - `mispredict_count_out` = 1, `branch_count_out` = 3.
- JAL at 0x200, imm 0x40 → predict taken, target 0x240. Resolution with `ex_predicted_taken_in` = 1 → no mispredict, BHT unchanged.
- JALR resolved with `ex_target_in` = 0x3000 and `ex_predicted_taken_in` = 0 → next cycle `mispredict_out` = 1, `redirect_pc_out` = 0x3000.
- Squash: mispredict resolved in cycle N; in cycle N+1 a mispredicting BNE is presented → it is ignored (no pulse in N+2, no BHT or count change).
- Aliasing and collision:
  - With INDEX_W=4, PCs 0x100 and 0x140 share an entry.
  - Training taken at 0x140 while fetching 0x100 in the same cycle → that fetch uses the old value; the next cycle uses the new value.
  - Asserting reset mid-sequence restores all entries to 01.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Bimodal branch predictor for the STRV32I front end.
//
// Predicts taken/not-taken and the next fetch PC from a table of 2-bit
// saturating counters indexed by pc[INDEX_W+1:2]. Resolved control transfers
// from execute train the table; a wrong prediction produces a registered
// one-cycle redirect pulse carrying the correct next PC.
//
// Ports:
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   fetch_valid_in                   fetch instruction valid (prediction is driven regardless)
//   fetch_pc_in / _opcode_6_to_2_in  fetch PC and opcode[6:2]
//   fetch_imm_in                     pre-decoded sign-extended B/J immediate
//   predict_taken_out                combinational taken prediction
//   predict_target_out               combinational predicted next PC
//   ex_valid_in, ex_pc_in            execute instruction valid and PC
//   ex_opcode_6_to_2_in              execute opcode[6:2]
//   ex_predicted_taken_in            prediction carried with the instruction
//   branch_taken_in, ex_target_in    resolved decision and target
//   mispredict_out, redirect_pc_out  registered redirect pulse and correct PC
//   branch_count_out                 resolved control transfers (wraps)
//   mispredict_count_out             mispredictions (wraps)
module branch_predictor_unit #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_pc_in,
  input  logic [4:0]  fetch_opcode_6_to_2_in,
  input  logic [31:0] fetch_imm_in,
  output logic        predict_taken_out,
  output logic [31:0] predict_target_out,
  input  logic        ex_valid_in,
  input  logic [31:0] ex_pc_in,
  input  logic [4:0]  ex_opcode_6_to_2_in,
  input  logic        ex_predicted_taken_in,
  input  logic        branch_taken_in,
  input  logic [31:0] ex_target_in,
  output logic        mispredict_out,
  output logic [31:0] redirect_pc_out,
  output logic [15:0] branch_count_out,
  output logic [15:0] mispredict_count_out
);

  localparam int unsigned Entries = 1 << INDEX_W;

  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;

  logic [Entries-1:0][1:0] bht_q, bht_d;
  logic                    mispredict_q, mispredict_d;
  logic [31:0]             redirect_q, redirect_d;
  logic [15:0]             branch_cnt_q, branch_cnt_d;
  logic [15:0]             mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] fetch_idx;
  logic [INDEX_W-1:0] ex_idx;
  logic [31:0]        fetch_pc_plus4;
  logic [31:0]        fetch_pc_imm;
  logic [31:0]        ex_pc_plus4;
  logic               res;
  logic               ex_is_ctrl;
  logic               ex_is_branch;
  logic [1:0]         ex_ctr;

  // fetch_valid_in is not needed: the prediction is always driven and the
  // consumer qualifies it.
  logic unused_fetch_valid;
  assign unused_fetch_valid = fetch_valid_in;

  assign fetch_idx      = fetch_pc_in[INDEX_W+1:2];
  assign ex_idx         = ex_pc_in[INDEX_W+1:2];
  assign fetch_pc_plus4 = fetch_pc_in + 32'd4;
  assign fetch_pc_imm   = fetch_pc_in + fetch_imm_in;
  assign ex_pc_plus4    = ex_pc_in + 32'd4;

  // Prediction reads the registered table, so a same-cycle update at the same
  // index is only seen by the next fetch.
  always_comb begin
    predict_taken_out  = 1'b0;
    predict_target_out = fetch_pc_plus4;
    case (fetch_opcode_6_to_2_in)
      OpJal: begin
        predict_taken_out  = 1'b1;
        predict_target_out = fetch_pc_imm;
      end
      OpBranch: begin
        predict_taken_out  = bht_q[fetch_idx][1];
        predict_target_out = bht_q[fetch_idx][1] ? fetch_pc_imm : fetch_pc_plus4;
      end
      default: begin
        // JALR target is unknown at fetch: fall through as not taken.
        predict_taken_out  = 1'b0;
        predict_target_out = fetch_pc_plus4;
      end
    endcase
  end

  // The instruction in execute while a redirect is in flight is on the wrong
  // path and must neither train nor count.
  assign res          = ex_valid_in & ~mispredict_q;
  assign ex_is_branch = (ex_opcode_6_to_2_in == OpBranch);
  assign ex_is_ctrl   = ex_is_branch | (ex_opcode_6_to_2_in == OpJal) |
                        (ex_opcode_6_to_2_in == OpJalr);
  assign ex_ctr       = bht_q[ex_idx];

  always_comb begin
    bht_d         = bht_q;
    mispredict_d  = res & ex_is_ctrl & (branch_taken_in != ex_predicted_taken_in);
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (res && ex_is_branch) begin
      if (branch_taken_in) begin
        bht_d[ex_idx] = (ex_ctr == 2'b11) ? ex_ctr : ex_ctr + 2'd1;
      end else begin
        bht_d[ex_idx] = (ex_ctr == 2'b00) ? ex_ctr : ex_ctr - 2'd1;
      end
    end

    if (res && ex_is_ctrl) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end

    if (mispredict_d) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
      redirect_d    = branch_taken_in ? ex_target_in : ex_pc_plus4;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bht_q         <= {Entries{2'b01}};
      mispredict_q  <= 1'b0;
      redirect_q    <= 32'd0;
      branch_cnt_q  <= 16'd0;
      mispred_cnt_q <= 16'd0;
    end else begin
      bht_q         <= bht_d;
      mispredict_q  <= mispredict_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict_out       = mispredict_q;
  assign redirect_pc_out      = redirect_q;
  assign branch_count_out     = branch_cnt_q;
  assign mispredict_count_out = mispred_cnt_q;

endmodule
